cnt_cmd_gen: RTL and testbench
==============================

// Module: cnt_cmd_gen
// PURPOSE
//  Command initiator for the loadable up/down counter FSM: accepts queued commands (LOAD/INC/DEC
//  plus repeat count) over a valid/ready interface, drives the counter's load/inc/d_in inputs.
//  Sits upstream of the counter; cnt_en marks cycles on which the counter must advance.
//  Needed because load=0,inc=0 means DEC on the counter: idle requires explicit gating.
// PARAMETERS
//  WIDTH       4  width of load value cmd_data / d_in
//  REP_W       4  width of repeat field; command executes cmd_rep+1 cycles
//  FIFO_DEPTH  4  command queue entries; power of 2, >=2
// PORTS
//  clk        in   1          rising-edge clock
//  reset_n    in   1          asynchronous active-low reset
//  cmd_valid  in   1          command offered
//  cmd_ready  out  1          queue can accept (= !full)
//  cmd_op     in   2          00 LOAD, 01 INC, 10 DEC, 11 reserved (dropped, no execution)
//  cmd_data   in   WIDTH      load value (LOAD only; ignored otherwise)
//  cmd_rep    in   REP_W      extra repeat cycles
//  load       out  1          to counter load
//  inc        out  1          to counter inc
//  d_in       out  WIDTH      to counter data input
//  cnt_en     out  1          counter advance enable; high only while executing
//  busy       out  1          executing or queue non-empty
//  done       out  1          high during final execution cycle of each command
// BEHAVIOUR
//  - Reset: load=0, inc=0, d_in=0, cnt_en=0, done=0, busy=0, cmd_ready=1, queue flushed, FSM IDLE.
//    Reset mid-command aborts it; queued commands discarded; no residual cnt_en.
//  - Push on edge where cmd_valid & cmd_ready. No push when full, even if a pop coincides.
//  - FSM states IDLE, RUN. IDLE: if queue non-empty, pop head -> RUN, load rep counter = cmd_rep.
//    RUN: each cycle rep counter decrements; at 0 with queue non-empty pop next, stay RUN
//    (back-to-back, no gap); at 0 with queue empty -> IDLE.
//  - All outputs registered. Latency: command pushed into empty queue at edge k -> first
//    execution cycle begins at edge k+1 (outputs valid after k+1); lasts cmd_rep+1 cycles.
//  - Execution encoding: LOAD load=1,inc=0,d_in=cmd_data; INC load=0,inc=1,d_in=0;
//    DEC load=0,inc=0,d_in=0. cnt_en=1 every execution cycle. Outside RUN all drive 0.
//  - Reserved op 11: popped and discarded in one cycle, cnt_en stays 0, done not pulsed.
//  - cmd_rep = max (all ones) gives 2^REP_W cycles; rep counter does not wrap early.
//  - busy = (state==RUN) | !empty; combinational from registers only.
// CONFIGURATION
//  CNT_CMD_GEN_STAT_EN defined: adds output stat_cmds [7:0], count of completed commands
//   (increments with done), saturates at 255, cleared by reset.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package cnt_cmd_pkg: op encodings OP_LOAD/OP_INC/OP_DEC/OP_RSVD, FSM state encodings,
//   command struct {op, data, rep}.
//  Sub-module cmd_fifo: synchronous FIFO, depth FIFO_DEPTH, width 2+WIDTH+REP_W, async
//   active-low reset, full/empty flags; top holds FSM, rep counter, output registers.
// TESTING
//  1 Reset: drive reset_n=0 mid-RUN -> all outputs 0, cmd_ready=1, busy=0 immediately.
//  2 Push LOAD data=4'hA rep=0 -> one cycle load=1,d_in=A,cnt_en=1,done=1, then all 0.
//  3 Push INC rep=2 then DEC rep=1 back-to-back -> inc=1 for 3 cycles, then 2 DEC cycles
//    (cnt_en=1, load=inc=0), no gap; done high on cycle 3 and cycle 5.
//  4 Hold outputs busy (INC rep=15), push 5 commands -> cmd_ready drops after 4 queued,
//    5th held until pop; all execute in order.
//  5 Push op=11 between two INC rep=0 -> two cnt_en cycles separated by a 1-cycle gap, no done for op 11.
//  6 STAT_EN build: 260 LOAD rep=0 commands -> stat_cmds saturates at 255.

Source files
------------

// File: rtl/cnt_cmd_pkg.sv
// Shared types for the counter command initiator: op codes, FSM states, command layout.
// Optional statistics counter is enabled by defining CNT_CMD_GEN_STAT_EN.
package cnt_cmd_pkg;

  localparam int CMD_DATA_W = 4;
  localparam int CMD_REP_W  = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Queue word layout, most significant field first: {op, data, rep}.
  typedef struct packed {
    op_e                   op;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_REP_W-1:0]  rep;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead synchronous command queue with full/empty flags; depth must be a power of 2.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A push is refused while full even if a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cnt_cmd_gen.sv
// Command initiator driving a load/inc/dec counter from a queue of repeatable commands.
// Define CNT_CMD_GEN_STAT_EN to add the saturating completed-command counter stat_cmds.
module cnt_cmd_gen
  import cnt_cmd_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int REP_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             load,
  output logic             inc,
  output logic [WIDTH-1:0] d_in,
  output logic             cnt_en,
  output logic             busy,
  output logic             done
`ifdef CNT_CMD_GEN_STAT_EN
  ,
  output logic [7:0]       stat_cmds
`endif
);

  localparam int FW = 2 + WIDTH + REP_W;

  state_e             state_q, state_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               load_q, load_d;
  logic               inc_q, inc_d;
  logic [WIDTH-1:0]   d_in_q, d_in_d;
  logic               cnt_en_q, cnt_en_d;
  logic               done_q, done_d;

  logic               fifo_full, fifo_empty, fifo_pop, take;
  logic [FW-1:0]      fifo_rdata;
  op_e                head_op;
  logic [WIDTH-1:0]   head_data;
  logic [REP_W-1:0]   head_rep;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .pop     (fifo_pop),
    .wdata   ({cmd_op, cmd_data, cmd_rep}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_op   = op_e'(fifo_rdata[FW-1 -: 2]);
  assign head_data = fifo_rdata[REP_W +: WIDTH];
  assign head_rep  = fifo_rdata[REP_W-1:0];

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q == ST_RUN) | ~fifo_empty;
  assign load      = load_q;
  assign inc       = inc_q;
  assign d_in      = d_in_q;
  assign cnt_en    = cnt_en_q;
  assign done      = done_q;

  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    load_d   = load_q;
    inc_d    = inc_q;
    d_in_d   = d_in_q;
    cnt_en_d = cnt_en_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    take     = 1'b0;

    unique case (state_q)
      ST_IDLE: take = ~fifo_empty;
      ST_RUN: begin
        if (rep_q != '0) begin
          rep_d  = rep_q - REP_W'(1);
          done_d = (rep_q == REP_W'(1));
        end else if (!fifo_empty) begin
          take = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          load_d   = 1'b0;
          inc_d    = 1'b0;
          d_in_d   = '0;
          cnt_en_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Popping loads the next command's encoding straight into the output registers,
    // so consecutive commands run with no gap; a reserved op only costs its pop cycle.
    if (take) begin
      fifo_pop = 1'b1;
      state_d  = ST_RUN;
      rep_d    = head_rep;
      done_d   = (head_rep == '0);
      cnt_en_d = 1'b1;
      load_d   = 1'b0;
      inc_d    = 1'b0;
      d_in_d   = '0;
      unique case (head_op)
        OP_LOAD: begin
          load_d = 1'b1;
          d_in_d = head_data;
        end
        OP_INC: inc_d = 1'b1;
        OP_DEC: begin
        end
        default: begin
          state_d  = ST_IDLE;
          rep_d    = '0;
          done_d   = 1'b0;
          cnt_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rep_q    <= '0;
      load_q   <= 1'b0;
      inc_q    <= 1'b0;
      d_in_q   <= '0;
      cnt_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      load_q   <= load_d;
      inc_q    <= inc_d;
      d_in_q   <= d_in_d;
      cnt_en_q <= cnt_en_d;
      done_q   <= done_d;
    end
  end

`ifdef CNT_CMD_GEN_STAT_EN
  logic [7:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (done_q && (stat_q != 8'hFF)) stat_d = stat_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stat_q <= 8'd0;
    else          stat_q <= stat_d;
  end

  assign stat_cmds = stat_q;
`endif

endmodule

// File: tb/tb_cnt_cmd_gen.sv
// Directed and randomized bench for cnt_cmd_gen against a command-level reference model.
module tb_cnt_cmd_gen;

  localparam int W = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [R-1:0] cmd_rep;
  logic         load, inc, cnt_en, busy, done;
  logic [W-1:0] d_in;
`ifdef CNT_CMD_GEN_STAT_EN
  logic [7:0]   stat_cmds;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int stat_model  = 0;
  logic         mon_en = 1'b0;
  logic [15:0]  cnt_hist = '0;
  logic [15:0]  done_hist = '0;
  logic [W+2:0] exp_q[$];

  cnt_cmd_gen #(.WIDTH(W), .REP_W(R), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_rep   (cmd_rep),
    .load      (load),
    .inc       (inc),
    .d_in      (d_in),
    .cnt_en    (cnt_en),
    .busy      (busy),
    .done      (done)
`ifdef CNT_CMD_GEN_STAT_EN
    ,
    .stat_cmds (stat_cmds)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each executed command is rep+1 cycles of {load, inc, d_in, done}.
  task automatic model_add(input logic [1:0] op, input logic [W-1:0] data, input logic [R-1:0] rep);
    if (op != 2'b11) begin
      for (int i = 0; i <= int'(rep); i++)
        exp_q.push_back({op == 2'b00, op == 2'b01, (op == 2'b00) ? data : {W{1'b0}}, i == int'(rep)});
      if (stat_model < 255) stat_model++;
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [W-1:0] data, input logic [R-1:0] rep);
    int n;
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_rep   = rep;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_add(op, data, rep);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy && n < max_cycles);
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    cnt_hist  <= {cnt_hist[14:0], cnt_en};
    done_hist <= {done_hist[14:0], done};
    if (mon_en) begin
      if (cnt_en) begin
        if (exp_q.size() == 0) check("mon_unexpected_exec", {31'd0, cnt_en}, 32'd0);
        else check("mon_exec", {25'd0, load, inc, d_in, done}, {25'd0, exp_q.pop_front()});
      end else begin
        check("mon_idle_outputs", {25'd0, load, inc, d_in, done}, 32'd0);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_rep   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {25'd0, load, inc, d_in, cnt_en}, 32'd0);
    check("reset_done_busy", {30'd0, done, busy}, 32'd0);
    check("reset_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single LOAD: idle after the push edge, one execution cycle on the next.
    push(2'b00, 4'hA, 4'd0);
    @(negedge clk);
    check("load_latency_cnt_en", {31'd0, cnt_en}, 32'd0);
    check("load_latency_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("load_exec", {24'd0, load, inc, d_in, cnt_en, done}, {24'd0, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1});
    @(negedge clk);
    check("load_after", {29'd0, cnt_en, busy, done}, 32'd0);

    // INC x3 then DEC x2 with no gap between them.
    push(2'b01, 4'h5, 4'd2);
    push(2'b10, 4'h3, 4'd1);
    wait_idle(50);
    check("b2b_cnt_en_pattern", {25'd0, cnt_hist[6:0]}, 32'b0111110);
    check("b2b_done_pattern", {25'd0, done_hist[6:0]}, 32'b0001010);

    // Reserved op between two single INCs leaves exactly one idle cycle.
    push(2'b01, 4'h0, 4'd0);
    push(2'b11, 4'h7, 4'd3);
    push(2'b01, 4'h0, 4'd0);
    wait_idle(50);
    check("rsvd_cnt_en_pattern", {27'd0, cnt_hist[4:0]}, 32'b01010);
    check("rsvd_done_pattern", {27'd0, done_hist[4:0]}, 32'b01010);

    // Long INC occupies the executor while the queue fills up.
    push(2'b01, 4'h0, 4'hF);
    for (int i = 0; i < 4; i++)
      push(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom_range(0, 3)));
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    push(2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom_range(0, 3)));
    wait_idle(400);
    check("full_all_executed", exp_q.size(), 32'd0);

    // Random mix including reserved ops and idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom_range(0, 3)));
    end
    wait_idle(600);
    check("random_all_executed", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a command with more queued behind it.
    push(2'b01, 4'h0, 4'd10);
    push(2'b00, 4'h9, 4'd1);
    push(2'b10, 4'h0, 4'd2);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {25'd0, load, inc, d_in, cnt_en}, 32'd0);
    check("midrun_reset_done_busy", {30'd0, done, busy}, 32'd0);
    check("midrun_reset_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    stat_model = 0;
`ifdef CNT_CMD_GEN_STAT_EN
    check("stat_reset", {24'd0, stat_cmds}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("post_reset_idle", {30'd0, cnt_en, busy}, 32'd0);

`ifdef CNT_CMD_GEN_STAT_EN
    for (int i = 0; i < 260; i++) push(2'b00, 4'($urandom), 4'd0);
    wait_idle(100);
    check("stat_saturate", {24'd0, stat_cmds}, 32'(stat_model));
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
